// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer_pkg
//  Brief    : Shared widths, FSM state encoding and ALU opcode constants for
//             the ALU operand/write-back sequencer and its register file.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

    // Default data and register-file address widths (must match the ALU)
    localparam int ALU_DW = 16;
    localparam int ALU_AW = 3;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } seq_state_t;

    // Flags as delivered by the ALU, kept in {N,Z,C} order
    typedef struct packed {
        logic n;
        logic z;
        logic c;
    } alu_flags_t;

    // ALU opcodes, shared with the ALU; this block never decodes them
    localparam logic [3:0] C_PASS_S = 4'h0;
    localparam logic [3:0] C_PASS_R = 4'h1;
    localparam logic [3:0] C_AND    = 4'h2;
    localparam logic [3:0] C_OR     = 4'h3;
    localparam logic [3:0] C_ADD    = 4'h4;
    localparam logic [3:0] C_SUB    = 4'h5;
    localparam logic [3:0] C_XOR    = 4'h6;
    localparam logic [3:0] C_SHL    = 4'h7;
    localparam logic [3:0] C_SHR    = 4'h8;
    localparam logic [3:0] C_INC    = 4'h9;
    localparam logic [3:0] C_DEC    = 4'hA;
    localparam logic [3:0] C_NOT    = 4'hB;
    localparam logic [3:0] C_NEG_S  = 4'hC;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_regfile8x16.sv
`default_nettype none
// ============================================================================
//  Module   : regfile8x16
//  Brief    : 2^AW x DW register file with two combinational operand read
//             ports, a combinational debug read port and one synchronous
//             write port. Cleared asynchronously by reset_n.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile8x16
    import alu_sequencer_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int AW = ALU_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] w_adr,
    input  logic [DW-1:0] w_data,
    input  logic [AW-1:0] r_adr,
    output logic [DW-1:0] r_data,
    input  logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_data,
    input  logic [AW-1:0] dbg_adr,
    output logic [DW-1:0] dbg_data
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] r_mem [NREG];

    // Storage: every word cleared on reset, single write port otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[w_adr] <= w_data;
        end
    end

    assign r_data   = r_mem[r_adr];
    assign s_data   = r_mem[s_adr];
    assign dbg_data = r_mem[dbg_adr];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Brief    : Three-cycle operand fetch / execute / write-back stage around
//             an external combinational 16-bit ALU. Accepts one command per
//             handshake, drives the ALU from latched operands, captures Y and
//             flags, writes back to the register file and status register.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int DW = ALU_DW,
    parameter int AW = ALU_AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_r_adr,
    input  logic [AW-1:0] cmd_s_adr,
    input  logic [AW-1:0] cmd_w_adr,
    input  logic          cmd_imm_sel,
    input  logic [DW-1:0] cmd_imm,
    input  logic          cmd_wb,
    input  logic          cmd_flag_we,
    output logic [DW-1:0] alu_r,
    output logic [DW-1:0] alu_s,
    output logic [3:0]    alu_op,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          alu_c,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [2:0]    stat,
    input  logic [AW-1:0] dbg_adr,
    output logic [DW-1:0] dbg_data
);

    seq_state_t    r_state;
    seq_state_t    w_state_nxt;

    logic [3:0]    r_op;
    logic [DW-1:0] r_opr_r;
    logic [DW-1:0] r_opr_s;
    logic [AW-1:0] r_w_adr;
    logic          r_wb;
    logic          r_flag_we;
    logic [DW-1:0] r_result;
    alu_flags_t    r_flags;
    alu_flags_t    r_stat;

    logic          w_ready;
    logic          w_done;
    logic          w_rf_we;
    logic          w_accept;
    logic [DW-1:0] w_rd_r;
    logic [DW-1:0] w_rd_s;

    regfile8x16 #(
        .DW (DW),
        .AW (AW)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (w_rf_we),
        .w_adr    (r_w_adr),
        .w_data   (r_result),
        .r_adr    (cmd_r_adr),
        .r_data   (w_rd_r),
        .s_adr    (cmd_s_adr),
        .s_data   (w_rd_s),
        .dbg_adr  (dbg_adr),
        .dbg_data (dbg_data)
    );

    // FSM state register; reset aborts any command in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus handshake, done and write-enable decode
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        w_rf_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_WB;
            end
            ST_WB: begin
                w_done      = 1'b1;
                w_rf_we     = r_wb;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_accept = cmd_valid && w_ready;

    // Command latch: loaded only on accept, so the ALU inputs hold steady
    // through WB and IDLE and the ALU outputs do not toggle needlessly
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= '0;
            r_opr_r   <= '0;
            r_opr_s   <= '0;
            r_w_adr   <= '0;
            r_wb      <= 1'b0;
            r_flag_we <= 1'b0;
        end else if (w_accept) begin
            r_op      <= cmd_op;
            r_opr_r   <= w_rd_r;
            r_opr_s   <= cmd_imm_sel ? cmd_imm : w_rd_s;
            r_w_adr   <= cmd_w_adr;
            r_wb      <= cmd_wb;
            r_flag_we <= cmd_flag_we;
        end
    end

    // Capture ALU result and flags at the end of EXEC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result <= '0;
            r_flags  <= '0;
        end else if (r_state == ST_EXEC) begin
            r_result <= alu_y;
            r_flags  <= {alu_n, alu_z, alu_c};
        end
    end

    // Status register: committed from the captured flags during WB
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat <= '0;
        end else if ((r_state == ST_WB) && r_flag_we) begin
            r_stat <= r_flags;
        end
    end

    assign cmd_ready = w_ready;
    assign done      = w_done;
    assign alu_r     = r_opr_r;
    assign alu_s     = r_opr_s;
    assign alu_op    = r_op;
    assign result    = r_result;
    assign stat      = r_stat;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Brief    : Self-checking bench for alu_sequencer. Provides a behavioural
//             ALU, keeps a register-file/status model and checks each
//             feature in its own task.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_r_adr;
    logic [2:0]  cmd_s_adr;
    logic [2:0]  cmd_w_adr;
    logic        cmd_imm_sel;
    logic [15:0] cmd_imm;
    logic        cmd_wb;
    logic        cmd_flag_we;
    logic [15:0] alu_r;
    logic [15:0] alu_s;
    logic [3:0]  alu_op;
    logic [15:0] alu_y;
    logic        alu_n;
    logic        alu_z;
    logic        alu_c;
    logic        done;
    logic [15:0] result;
    logic [2:0]  stat;
    logic [2:0]  dbg_adr;
    logic [15:0] dbg_data;

    int total;
    int bad;

    // reference model state
    logic [15:0] ref_rf [8];
    logic [2:0]  ref_stat;

    // observations and predictions of the most recent send()
    logic        ob_tmo;
    logic        ob_d0, ob_d1, ob_d2;
    logic [15:0] ob_r, ob_s, ob_result, ob_dbg;
    logic [3:0]  ob_op;
    logic [2:0]  ob_stat;
    logic [15:0] ex_r, ex_s, ex_y;

    alu_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_r_adr   (cmd_r_adr),
        .cmd_s_adr   (cmd_s_adr),
        .cmd_w_adr   (cmd_w_adr),
        .cmd_imm_sel (cmd_imm_sel),
        .cmd_imm     (cmd_imm),
        .cmd_wb      (cmd_wb),
        .cmd_flag_we (cmd_flag_we),
        .alu_r       (alu_r),
        .alu_s       (alu_s),
        .alu_op      (alu_op),
        .alu_y       (alu_y),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .alu_c       (alu_c),
        .done        (done),
        .result      (result),
        .stat        (stat),
        .dbg_adr     (dbg_adr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {N, Z, C, Y}
    function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] r, input logic [15:0] s);
        logic [16:0] t;
        logic [15:0] y;
        logic        c;
        c = 1'b0;
        case (op)
            4'h0: y = s;
            4'h1: y = r;
            4'h2: y = r & s;
            4'h3: y = r | s;
            4'h4: begin t = {1'b0, r} + {1'b0, s}; y = t[15:0]; c = t[16]; end
            4'h5: begin y = r - s; c = (r < s); end
            4'h6: y = r ^ s;
            4'h7: begin y = {s[14:0], 1'b0}; c = s[15]; end
            4'h8: begin y = {1'b0, s[15:1]}; c = s[0]; end
            4'h9: begin y = s + 16'd1; c = (s == 16'hFFFF); end
            4'hA: begin y = s - 16'd1; c = (s == 16'h0000); end
            4'hB: y = ~s;
            4'hC: y = 16'd0 - s;
            default: y = s;
        endcase
        return {y[15], (y == 16'd0), c, y};
    endfunction

    assign {alu_n, alu_z, alu_c, alu_y} = alu_fn(alu_op, alu_r, alu_s);

    task automatic model_clear();
        for (int i = 0; i < 8; i++) ref_rf[i] = 16'd0;
        ref_stat = 3'b000;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] sa, input logic [2:0] wa,
                             input logic isel, input logic [15:0] imm, input logic wb, input logic fwe);
        cmd_op = op; cmd_r_adr = ra; cmd_s_adr = sa; cmd_w_adr = wa;
        cmd_imm_sel = isel; cmd_imm = imm; cmd_wb = wb; cmd_flag_we = fwe;
    endtask

    // Issue one command, record what the DUT shows in EXEC, WB and the
    // following IDLE cycle, and advance the reference model
    task automatic send(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] sa, input logic [2:0] wa,
                        input logic isel, input logic [15:0] imm, input logic wb, input logic fwe);
        logic [18:0] f;
        int waitc;
        ex_r = ref_rf[ra];
        ex_s = isel ? imm : ref_rf[sa];
        f    = alu_fn(op, ex_r, ex_s);
        ex_y = f[15:0];
        drive_cmd(op, ra, sa, wa, isel, imm, wb, fwe);
        cmd_valid = 1'b1;
        waitc = 0;
        @(negedge clk);
        while (!cmd_ready && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        ob_tmo = !cmd_ready;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        ob_r = alu_r; ob_s = alu_s; ob_op = alu_op; ob_d0 = done;
        @(posedge clk); #1;
        ob_d1 = done; ob_result = result;
        @(posedge clk); #1;
        ob_d2 = done; ob_stat = stat;
        if (wb)  ref_rf[wa] = ex_y;
        if (fwe) ref_stat = f[18:16];
        dbg_adr = wa; #1;
        ob_dbg = dbg_data;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (stat !== 3'b000) begin bad++; $display("FAIL rst_stat: got %b want 000", stat); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL rst_result: got %h want 0000", result); end
        total++; if ({alu_r, alu_s, alu_op} !== 36'd0) begin bad++; $display("FAIL rst_alu_in: got %h %h %h want 0", alu_r, alu_s, alu_op); end
        for (int a = 0; a < 8; a++) begin
            dbg_adr = 3'(a); #1;
            total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL rst_dbg[%0d]: got %h want 0000", a, dbg_data); end
        end
    endtask

    task automatic test_imm_load();
        send(4'h0, 3'd0, 3'd0, 3'd3, 1'b1, 16'h1234, 1'b1, 1'b1);
        total++; if (ob_tmo) begin bad++; $display("FAIL imm_accept: got timeout want accept"); end
        total++; if ({ob_d0, ob_d1, ob_d2} !== 3'b010) begin bad++; $display("FAIL imm_done: got %b want 010", {ob_d0, ob_d1, ob_d2}); end
        total++; if (ob_s !== 16'h1234 || ob_op !== 4'h0) begin bad++; $display("FAIL imm_alu_s: got %h op %h want 1234 op 0", ob_s, ob_op); end
        total++; if (ob_dbg !== 16'h1234) begin bad++; $display("FAIL imm_r3: got %h want 1234", ob_dbg); end
        total++; if (ob_stat !== 3'b000) begin bad++; $display("FAIL imm_stat: got %b want 000", ob_stat); end
    endtask

    task automatic test_add_sub();
        send(4'h0, 3'd0, 3'd0, 3'd1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        send(4'h0, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0001, 1'b1, 1'b0);
        send(4'h4, 3'd1, 3'd2, 3'd4, 1'b0, 16'h0000, 1'b1, 1'b1);
        total++; if (ob_r !== 16'hFFFF || ob_s !== 16'h0001) begin bad++; $display("FAIL add_opnd: got %h %h want ffff 0001", ob_r, ob_s); end
        total++; if (ob_dbg !== 16'h0000 || ob_result !== 16'h0000) begin bad++; $display("FAIL add_r4: got %h res %h want 0000", ob_dbg, ob_result); end
        total++; if (ob_stat !== 3'b011) begin bad++; $display("FAIL add_stat: got %b want 011", ob_stat); end
        send(4'h0, 3'd0, 3'd0, 3'd5, 1'b1, 16'h0003, 1'b1, 1'b0);
        send(4'h0, 3'd0, 3'd0, 3'd6, 1'b1, 16'h0005, 1'b1, 1'b0);
        send(4'h5, 3'd5, 3'd6, 3'd7, 1'b0, 16'h0000, 1'b1, 1'b1);
        total++; if (ob_dbg !== 16'hFFFE) begin bad++; $display("FAIL sub_r7: got %h want fffe", ob_dbg); end
        total++; if (ob_stat !== 3'b101) begin bad++; $display("FAIL sub_stat: got %b want 101", ob_stat); end
    endtask

    task automatic test_shift();
        send(4'h7, 3'd0, 3'd0, 3'd2, 1'b1, 16'h8001, 1'b1, 1'b1);
        total++; if (ob_dbg !== 16'h0002 || ob_result !== 16'h0002) begin bad++; $display("FAIL shl_r2: got %h res %h want 0002", ob_dbg, ob_result); end
        total++; if (ob_stat !== 3'b001) begin bad++; $display("FAIL shl_stat: got %b want 001", ob_stat); end
        send(4'h7, 3'd0, 3'd0, 3'd3, 1'b1, 16'h4000, 1'b1, 1'b0);
        total++; if (ob_dbg !== 16'h8000) begin bad++; $display("FAIL shl_nofl_r3: got %h want 8000", ob_dbg); end
        total++; if (ob_stat !== 3'b001) begin bad++; $display("FAIL shl_nofl_stat: got %b want 001", ob_stat); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [18:0] f;
        logic [5:0]  rdy;
        logic [5:0]  dn;
        logic [3:0]  op_second;
        int waitc;
        a = 16'($urandom);
        drive_cmd(4'h0, 3'd0, 3'd0, 3'd5, 1'b1, a, 1'b1, 1'b1);
        cmd_valid = 1'b1;
        waitc = 0;
        @(negedge clk);
        while (!cmd_ready && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        total++; if (!cmd_ready) begin bad++; $display("FAIL b2b_first_accept: got timeout want accept"); end
        @(posedge clk); #1;
        rdy[0] = cmd_ready; dn[0] = done;
        drive_cmd(4'h4, 3'd5, 3'd5, 3'd6, 1'b0, 16'h0000, 1'b1, 1'b1);
        op_second = 4'h0;
        for (int k = 1; k < 6; k++) begin
            @(posedge clk); #1;
            rdy[k] = cmd_ready; dn[k] = done;
            if (k == 3) begin
                op_second = alu_op;
                cmd_valid = 1'b0;
            end
        end
        ref_rf[5] = a;
        f = alu_fn(4'h4, a, a);
        ref_rf[6] = f[15:0];
        ref_stat  = f[18:16];
        total++; if (rdy !== 6'b100100) begin bad++; $display("FAIL b2b_ready: got %b want 100100", rdy); end
        total++; if (dn !== 6'b010010) begin bad++; $display("FAIL b2b_done: got %b want 010010", dn); end
        total++; if (op_second !== 4'h4) begin bad++; $display("FAIL b2b_second_op: got %h want 4", op_second); end
        dbg_adr = 3'd6; #1;
        total++; if (dbg_data !== ref_rf[6]) begin bad++; $display("FAIL b2b_raw_r6: got %h want %h", dbg_data, ref_rf[6]); end
        total++; if (stat !== ref_stat) begin bad++; $display("FAIL b2b_stat: got %b want %b", stat, ref_stat); end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [2:0]  ra, sa, wa, pa;
        logic        isel, wb, fwe;
        logic [15:0] imm;
        for (int n = 0; n < 24; n++) begin
            op   = 4'($urandom);
            ra   = 3'($urandom);
            sa   = 3'($urandom);
            wa   = 3'($urandom);
            isel = 1'($urandom);
            imm  = 16'($urandom);
            wb   = ($urandom_range(0, 3) != 0);
            fwe  = 1'($urandom);
            send(op, ra, sa, wa, isel, imm, wb, fwe);
            total++; if (ob_tmo || {ob_d0, ob_d1, ob_d2} !== 3'b010) begin bad++; $display("FAIL rnd%0d_done: tmo %b got %b want 010", n, ob_tmo, {ob_d0, ob_d1, ob_d2}); end
            total++; if (ob_r !== ex_r || ob_s !== ex_s || ob_op !== op) begin bad++; $display("FAIL rnd%0d_alu_in: got %h %h %h want %h %h %h", n, ob_r, ob_s, ob_op, ex_r, ex_s, op); end
            total++; if (ob_result !== ex_y) begin bad++; $display("FAIL rnd%0d_result: got %h want %h", n, ob_result, ex_y); end
            total++; if (ob_stat !== ref_stat) begin bad++; $display("FAIL rnd%0d_stat: got %b want %b", n, ob_stat, ref_stat); end
            total++; if (ob_dbg !== ref_rf[wa]) begin bad++; $display("FAIL rnd%0d_wreg: got %h want %h", n, ob_dbg, ref_rf[wa]); end
            pa = 3'($urandom);
            dbg_adr = pa; #1;
            total++; if (dbg_data !== ref_rf[pa]) begin bad++; $display("FAIL rnd%0d_dbg[%0d]: got %h want %h", n, pa, dbg_data, ref_rf[pa]); end
        end
    endtask

    task automatic test_reset_mid();
        logic saw_done;
        int waitc;
        send(4'h0, 3'd0, 3'd0, 3'd2, 1'b1, 16'h00AA, 1'b1, 1'b0);
        total++; if (ob_dbg !== 16'h00AA) begin bad++; $display("FAIL rmid_preload: got %h want 00aa", ob_dbg); end
        drive_cmd(4'h0, 3'd0, 3'd0, 3'd2, 1'b1, 16'h5555, 1'b1, 1'b1);
        cmd_valid = 1'b1;
        waitc = 0;
        @(negedge clk);
        while (!cmd_ready && waitc < 8) begin
            @(negedge clk);
            waitc++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b0 || alu_s !== 16'h5555) begin bad++; $display("FAIL rmid_in_exec: got ready %b s %h want 0 5555", cmd_ready, alu_s); end
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        total++; if (cmd_ready !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL rmid_fsm: got ready %b done %b want 1 0", cmd_ready, done); end
        total++; if (stat !== 3'b000 || result !== 16'h0000 || alu_op !== 4'h0) begin bad++; $display("FAIL rmid_regs: got %b %h %h want 000 0000 0", stat, result, alu_op); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done !== 1'b0) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rmid_no_done: got %b want 0", saw_done); end
        dbg_adr = 3'd2; #1;
        total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL rmid_r2: got %h want 0000", dbg_data); end
        total++; if (stat !== 3'b000) begin bad++; $display("FAIL rmid_stat_after: got %b want 000", stat); end
        send(4'h0, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0F0F, 1'b1, 1'b1);
        total++; if (ob_tmo || {ob_d0, ob_d1, ob_d2} !== 3'b010) begin bad++; $display("FAIL rmid_next_done: tmo %b got %b want 010", ob_tmo, {ob_d0, ob_d1, ob_d2}); end
        total++; if (ob_dbg !== 16'h0F0F) begin bad++; $display("FAIL rmid_next_r2: got %h want 0f0f", ob_dbg); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        dbg_adr = 3'd0;
        drive_cmd(4'h0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
        model_clear();
        test_reset();
        test_imm_load();
        test_add_sub();
        test_shift();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle operand/write-back stage that sits directly upstream and downstream of the 16-bit ALU. Accepts one command per handshake, reads two operands from an internal 8×16 register file (or substitutes an immediate for S), and drives the ALU's R, S and op inputs. It then captures Y and the N/Z/C flags, writes Y back to the destination register and updates a status register. The ALU stays a separate combinational module instantiated alongside this block; this block owns all state.

## Interface
- DW, 16, data width; must match the ALU width
- AW, 3, register-file address width (2^AW registers)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  4  ALU opcode, forwarded unmodified
- cmd_r_adr  in  AW  R-operand register
- cmd_s_adr  in  AW  S-operand register
- cmd_w_adr  in  AW  destination register
- cmd_imm_sel  in  1  1 = S comes from cmd_imm, not the register file
- cmd_imm  in  DW  immediate S value
- cmd_wb  in  1  1 = write Y to cmd_w_adr
- cmd_flag_we  in  1  1 = update the status register
- alu_r, alu_s  out  DW  operands to the ALU
- alu_op  out  4  opcode to the ALU
- alu_y  in  DW  ALU result
- alu_n, alu_z, alu_c  in  1  ALU flags
- done  out  1  one-cycle pulse on write-back
- result  out  DW  last captured Y
- stat  out  3  {N,Z,C} status register
- dbg_adr  in  AW  debug read address
- dbg_data  out  DW  combinational read of regfile[dbg_adr]

## Operation
- FSM states and transitions:
  - IDLE → EXEC on cmd_valid && cmd_ready.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- cmd_ready = 1 only in IDLE. A command is accepted only on a clock edge where both cmd_valid and cmd_ready are 1.
- On accept, latch op, w_adr, wb, flag_we and both operands:
  - R = regfile[r_adr].
  - S = imm_sel ? imm : regfile[s_adr].
- EXEC: alu_r, alu_s and alu_op are driven from the latches. At the end of EXEC, capture alu_y into result and the flags into a temporary.
- WB:
  - If wb, regfile[w_adr] ← result.
  - If flag_we, stat ← captured {N,Z,C}.
  - done = 1.
- Outside EXEC, alu_r, alu_s and alu_op hold their last values, so the ALU outputs remain stable.
- Opcode rules:
  - Opcodes 1101–1111 are forwarded unchanged; the ALU defines their result (pass S).
  - No op decoding occurs in this block. C semantics, including the shift carry, are taken verbatim from alu_c.
- Register 0 is an ordinary register; none is hardwired.
- Write-back completes before the next accept, so read-after-write needs no bypass.
- Reset (any time, including mid-EXEC or mid-WB):
  - Return to IDLE and abort the command; no write-back and no flag update.
  - All registers 0; stat = 3'b000; result = 0; alu_r, alu_s, alu_op = 0; done = 0; cmd_ready = 1 once reset_n is released.

## Timing
- Accept edge T. EXEC occupies cycle T+1, WB occupies cycle T+2, and done is high during T+2.
- The regfile write and the stat update are visible from edge T+3.
- The earliest next accept is edge T+3, giving a throughput of 1 command per 3 cycles.
- cmd_valid held high across a busy period is not lost; it is accepted at the first IDLE edge.
- The ALU path is combinational within EXEC, so ALU delay plus capture setup must fit in one clock period.
- dbg_data is purely combinational and reflects a write from edge T+3 onward.

## Structure
- Shared package/include:
  - DW and AW defaults.
  - FSM state encodings: IDLE = 2'b00, EXEC = 2'b01, WB = 2'b10.
  - ALU opcode constants (PASS_S = 4'h0 … NEG_S = 4'hC), shared with the ALU.
- One sub-module, regfile8x16:
  - Two combinational read ports plus a debug read port.
  - One synchronous write port.
  - Asynchronous active-low clear.
- The FSM and latches stay in alu_sequencer.

## Test plan
- **Reset values:** reset_n low → cmd_ready = 1 after release, done = 0, stat = 000, and dbg_data = 0 for every dbg_adr.
- **Immediate load:** op 0000, imm_sel = 1, imm 0x1234, w_adr 3, wb = 1, flag_we = 1 → done at T+2; from T+3, regfile[3] = 0x1234 and stat = 000.
- **Add with carry:** r1 = 0xFFFF, r2 = 0x0001, op 0100 R = 1 S = 2 → 4 → r4 = 0x0000, stat = {0,1,1}. Then subtract r5 = 0x0003, r6 = 0x0005, op 0101 → r7 = 0xFFFE, stat = {1,0,1}.
- **Left shift carry:** op 0111 with S = 0x8001 → Y = 0x0002 and C = 1 (alu_c passed unchanged), stat = {0,0,1}. With flag_we = 0, stat is unchanged while the register is still written.
- **Held cmd_valid:** cmd_valid held high with two commands queued by the bench → cmd_ready low for 2 cycles, second accept exactly 3 cycles after the first, two done pulses 3 cycles apart.
- **Reset mid-operation:** reset_n pulsed low during EXEC of a write to r2 (prior value 0x00AA) → r2 reads 0 (cleared by reset, not 0x00AA written back), no done pulse, FSM in IDLE, and the next command executes normally.
